dsp_fir_tap_sequencer: RTL and testbench

//  Time-multiplexes one dsp_t1_10x9x32 MAC across NTAPS FIR taps.
//  - Accepts 9-bit samples (valid/ready) and keeps a sample delay line.
//  - Issues one coefficient x sample product per cycle on the DSP port bundle.
//  - Captures the accumulated z_o and presents it on a valid/ready result port.
//  - Sits between the sample stream and an instanced DSP configured for multiply-accumulate.

---
 rtl/dsp_fir_tap_sequencer_if.sv | 32 +++
 rtl/dsp_fir_tap_sequencer.sv | 145 ++++++++++++++
 tb/tb_dsp_fir_tap_sequencer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_fir_tap_sequencer_if.sv
// Sample stream, result stream and DSP port bundle of the FIR tap sequencer.
// Signal suffixes are relative to the sequencer: the sequencer uses the slave
// modport and the environment (source, sink, DSP) uses the master modport.
interface dsp_fir_tap_sequencer_if #(
  parameter int unsigned ZW = 19
);
  logic [8:0]    s_data_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic          flush_i;
  logic [ZW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic          busy_o;
  logic [9:0]    dsp_a_o;
  logic [8:0]    dsp_b_o;
  logic [2:0]    dsp_feedback_o;
  logic          dsp_load_acc_o;
  logic [ZW-1:0] dsp_z_i;

  modport slave (
    input  s_data_i, s_valid_i, flush_i, m_ready_i, dsp_z_i,
    output s_ready_o, m_data_o, m_valid_o, busy_o,
    output dsp_a_o, dsp_b_o, dsp_feedback_o, dsp_load_acc_o
  );

  modport master (
    output s_data_i, s_valid_i, flush_i, m_ready_i, dsp_z_i,
    input  s_ready_o, m_data_o, m_valid_o, busy_o,
    input  dsp_a_o, dsp_b_o, dsp_feedback_o, dsp_load_acc_o
  );
endinterface

// File: rtl/dsp_fir_tap_sequencer.sv
// Time-multiplexes one external multiply-accumulate DSP across NTAPS FIR taps.
// Each accepted sample shifts the delay line, issues NTAPS coefficient x sample
// ops (first op clears the accumulator), waits out the DSP latency and holds
// the captured sum on the result port until it is consumed.
module dsp_fir_tap_sequencer #(
  parameter int unsigned         NTAPS       = 4,
  parameter logic [10*NTAPS-1:0] COEFF       = {10'h044, 10'h033, 10'h022, 10'h011},
  parameter int unsigned         DSP_LATENCY = 1,
  parameter int unsigned         ZW          = 19
) (
  input logic                    clock_i,
  input logic                    reset_n_i,
  dsp_fir_tap_sequencer_if.slave bus
);
  localparam int unsigned TW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int unsigned WW = 2;
  localparam int unsigned SW = 9;
  localparam int unsigned CW = 10;
  localparam int unsigned FW = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tap_q, tap_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [SW-1:0]   dline_q [NTAPS];
  logic [SW-1:0]   dline_d [NTAPS];
  logic            s_ready_q, s_ready_d;
  logic            busy_q, busy_d;
  logic [ZW-1:0]   m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d;
  logic [CW-1:0]   dsp_a_q, dsp_a_d;
  logic [SW-1:0]   dsp_b_q, dsp_b_d;
  logic [FW-1:0]   dsp_fb_q, dsp_fb_d;
  logic            dsp_load_q, dsp_load_d;

  // State, delay line and registered outputs; synchronous active-low reset
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      tap_q      <= '0;
      wait_q     <= '0;
      dline_q    <= '{default: '0};
      s_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      dsp_a_q    <= '0;
      dsp_b_q    <= '0;
      dsp_fb_q   <= '0;
      dsp_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      wait_q     <= wait_d;
      dline_q    <= dline_d;
      s_ready_q  <= s_ready_d;
      busy_q     <= busy_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      dsp_a_q    <= dsp_a_d;
      dsp_b_q    <= dsp_b_d;
      dsp_fb_q   <= dsp_fb_d;
      dsp_load_q <= dsp_load_d;
    end
  end

  // Next state, delay-line update and next values of every registered output
  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    wait_d     = wait_q;
    dline_d    = dline_q;
    s_ready_d  = 1'b0;
    busy_d     = 1'b0;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    dsp_a_d    = '0;
    dsp_b_d    = '0;
    dsp_fb_d   = '0;
    dsp_load_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // flush takes priority over a simultaneous sample
        if (bus.flush_i) begin
          dline_d = '{default: '0};
        end else if (bus.s_valid_i && s_ready_q) begin
          dline_d[0] = bus.s_data_i;
          for (int k = 1; k < NTAPS; k++) begin
            dline_d[k] = dline_q[k-1];
          end
          tap_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        dsp_a_d    = COEFF[CW*32'(tap_q) +: CW];
        dsp_b_d    = dline_q[tap_q];
        dsp_load_d = 1'b1;
        dsp_fb_d   = (tap_q == '0) ? FW'(1) : FW'(0);
        if (tap_q == TW'(NTAPS - 1)) begin
          wait_d  = WW'(DSP_LATENCY);
          state_d = S_WAIT;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          m_data_d  = bus.dsp_z_i;
          m_valid_d = 1'b1;
          state_d   = S_HOLD;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.m_ready_i) begin
          m_valid_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // ready only while idle, and dropped for the cycle after a flush
    s_ready_d = (state_d == S_IDLE) && !((state_q == S_IDLE) && bus.flush_i);
    busy_d    = (state_d != S_IDLE);
  end

  assign bus.s_ready_o      = s_ready_q;
  assign bus.busy_o         = busy_q;
  assign bus.m_data_o       = m_data_q;
  assign bus.m_valid_o      = m_valid_q;
  assign bus.dsp_a_o        = dsp_a_q;
  assign bus.dsp_b_o        = dsp_b_q;
  assign bus.dsp_feedback_o = dsp_fb_q;
  assign bus.dsp_load_acc_o = dsp_load_q;
endmodule

// File: tb/tb_dsp_fir_tap_sequencer.sv
// Bench for dsp_fir_tap_sequencer: directed and random samples against a
// delay-line FIR reference, with behavioural MAC models on the DSP ports.
module tb_dsp_fir_tap_sequencer;
  localparam int unsigned NTAPS = 4;
  localparam int unsigned ZW    = 19;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dsp_fir_tap_sequencer_if #(.ZW(ZW)) ifc ();
  dsp_fir_tap_sequencer_if #(.ZW(ZW)) ifc3 ();

  dsp_fir_tap_sequencer #(.NTAPS(NTAPS), .DSP_LATENCY(1), .ZW(ZW)) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .bus       (ifc.slave)
  );

  dsp_fir_tap_sequencer #(.NTAPS(NTAPS), .DSP_LATENCY(3), .ZW(ZW)) dut3 (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .bus       (ifc3.slave)
  );

  // 1-cycle MAC for the default build
  logic [31:0] acc1 = '0;
  always @(posedge clk) begin
    if (ifc.dsp_load_acc_o) begin
      if (ifc.dsp_feedback_o == 3'd1) acc1 <= 32'(ifc.dsp_a_o) * 32'(ifc.dsp_b_o);
      else acc1 <= acc1 + 32'(ifc.dsp_a_o) * 32'(ifc.dsp_b_o);
    end
  end
  assign ifc.dsp_z_i = acc1[ZW-1:0];

  // 3-cycle MAC: accumulator followed by two pipeline stages
  logic [31:0] acc3 = '0;
  logic [31:0] p1 = '0;
  logic [31:0] p2 = '0;
  always @(posedge clk) begin
    if (ifc3.dsp_load_acc_o) begin
      if (ifc3.dsp_feedback_o == 3'd1) acc3 <= 32'(ifc3.dsp_a_o) * 32'(ifc3.dsp_b_o);
      else acc3 <= acc3 + 32'(ifc3.dsp_a_o) * 32'(ifc3.dsp_b_o);
    end
    p1 <= acc3;
    p2 <= p1;
  end
  assign ifc3.dsp_z_i = p2[ZW-1:0];

  int n_cmp = 0;
  int n_err = 0;
  int coeff [NTAPS] = '{17, 34, 51, 68};
  int hist  [NTAPS] = '{0, 0, 0, 0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_y();
    longint s;
    s = 0;
    for (int k = 0; k < NTAPS; k++) s += longint'(coeff[k]) * longint'(hist[k]);
    return int'(s & ((longint'(1) << ZW) - 1));
  endfunction

  function automatic void hist_push(input int x);
    for (int k = NTAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
  endfunction

  // Send one sample, check every issued op, latency and the result.
  // exp_i < 0 selects the reference model; hold > 0 stalls the result sink.
  task automatic do_sample(input logic [8:0] x, input int exp_i, input int hold);
    int cnt;
    int loads;
    int exp_v;
    logic [ZW-1:0] held;
    cnt = 0;
    while (!ifc.s_ready_o && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("s_ready_wait", 32'(ifc.s_ready_o), 32'd1);
    ifc.m_ready_i = (hold == 0);
    ifc.s_data_i  = x;
    ifc.s_valid_i = 1'b1;
    tick();
    ifc.s_valid_i = 1'b0;
    hist_push(int'(x));
    exp_v = (exp_i < 0) ? ref_y() : exp_i;
    cnt   = 0;
    loads = 0;
    while (!ifc.m_valid_o && cnt < 40) begin
      if (ifc.dsp_load_acc_o) begin
        if (loads < NTAPS) begin
          chk("op_feedback", 32'(ifc.dsp_feedback_o), (loads == 0) ? 32'd1 : 32'd0);
          chk("op_coeff", 32'(ifc.dsp_a_o), 32'(coeff[loads]));
          chk("op_sample", 32'(ifc.dsp_b_o), 32'(hist[loads]));
        end
        loads++;
      end
      tick();
      cnt++;
    end
    chk("load_cycles", 32'(loads), 32'(NTAPS));
    chk("latency", 32'(cnt), 32'(NTAPS + 2));
    chk("m_valid", 32'(ifc.m_valid_o), 32'd1);
    chk("m_data", 32'(ifc.m_data_o), 32'(exp_v));
    held = ifc.m_data_o;
    for (int i = 0; i < hold; i++) begin
      ifc.s_data_i  = 9'h1ff;
      ifc.s_valid_i = 1'b1;
      tick();
      chk("bp_valid", 32'(ifc.m_valid_o), 32'd1);
      chk("bp_data", 32'(ifc.m_data_o), 32'(held));
      chk("bp_s_ready", 32'(ifc.s_ready_o), 32'd0);
    end
    ifc.s_valid_i = 1'b0;
    ifc.m_ready_i = 1'b1;
    tick();
    chk("m_valid_clr", 32'(ifc.m_valid_o), 32'd0);
    chk("s_ready_back", 32'(ifc.s_ready_o), 32'd1);
  endtask

  initial begin
    int cnt;
    ifc.s_data_i  = '0;
    ifc.s_valid_i = 1'b0;
    ifc.flush_i   = 1'b0;
    ifc.m_ready_i = 1'b1;
    ifc3.s_data_i  = '0;
    ifc3.s_valid_i = 1'b0;
    ifc3.flush_i   = 1'b0;
    ifc3.m_ready_i = 1'b1;

    // reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_s_ready", 32'(ifc.s_ready_o), 32'd0);
    chk("rst_m_valid", 32'(ifc.m_valid_o), 32'd0);
    chk("rst_m_data", 32'(ifc.m_data_o), 32'd0);
    chk("rst_busy", 32'(ifc.busy_o), 32'd0);
    chk("rst_dsp_a", 32'(ifc.dsp_a_o), 32'd0);
    chk("rst_dsp_b", 32'(ifc.dsp_b_o), 32'd0);
    chk("rst_fb", 32'(ifc.dsp_feedback_o), 32'd0);
    chk("rst_load", 32'(ifc.dsp_load_acc_o), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_s_ready", 32'(ifc.s_ready_o), 32'd1);

    // impulse-style ramp, then a zero sample
    do_sample(9'd1, 17, 0);
    do_sample(9'd2, 68, 0);
    do_sample(9'd3, 170, 0);
    do_sample(9'd4, 340, 0);
    do_sample(9'd0, 425, 0);

    // backpressure for 10 cycles, then exactly one result
    do_sample(9'd7, 527, 10);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_single", 32'(ifc.m_valid_o), 32'd0);
      chk("bp_idle", 32'(ifc.busy_o), 32'd0);
    end

    // flush beats a simultaneous sample
    do_sample(9'd1, -1, 0);
    do_sample(9'd2, -1, 0);
    ifc.flush_i   = 1'b1;
    ifc.s_valid_i = 1'b1;
    ifc.s_data_i  = 9'd9;
    tick();
    ifc.flush_i   = 1'b0;
    ifc.s_valid_i = 1'b0;
    for (int k = 0; k < NTAPS; k++) hist[k] = 0;
    chk("flush_busy", 32'(ifc.busy_o), 32'd0);
    chk("flush_s_ready", 32'(ifc.s_ready_o), 32'd0);
    tick();
    chk("flush_ready_back", 32'(ifc.s_ready_o), 32'd1);
    do_sample(9'd5, 85, 0);

    // reset while tap 2 is current
    ifc.s_data_i  = 9'd3;
    ifc.s_valid_i = 1'b1;
    tick();
    ifc.s_valid_i = 1'b0;
    hist_push(3);
    tick();
    tick();
    chk("mid_load", 32'(ifc.dsp_load_acc_o), 32'd1);
    chk("mid_b", 32'(ifc.dsp_b_o), 32'(hist[1]));
    rst_n = 1'b0;
    tick();
    chk("mrst_busy", 32'(ifc.busy_o), 32'd0);
    chk("mrst_load", 32'(ifc.dsp_load_acc_o), 32'd0);
    chk("mrst_a", 32'(ifc.dsp_a_o), 32'd0);
    chk("mrst_b", 32'(ifc.dsp_b_o), 32'd0);
    chk("mrst_fb", 32'(ifc.dsp_feedback_o), 32'd0);
    chk("mrst_s_ready", 32'(ifc.s_ready_o), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < NTAPS; k++) hist[k] = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mrst_no_result", 32'(ifc.m_valid_o), 32'd0);
    end
    do_sample(9'd3, 51, 0);

    // random samples, gaps and short stalls against the reference
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      do_sample(9'($urandom_range(0, 511)), -1, int'($urandom_range(0, 2)));
    end

    // DSP_LATENCY=3 build
    chk("l3_s_ready", 32'(ifc3.s_ready_o), 32'd1);
    ifc3.s_data_i  = 9'd4;
    ifc3.s_valid_i = 1'b1;
    tick();
    ifc3.s_valid_i = 1'b0;
    cnt = 0;
    while (!ifc3.m_valid_o && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("l3_latency", 32'(cnt), 32'd8);
    chk("l3_m_data", 32'(ifc3.m_data_o), 32'd68);
    tick();
    chk("l3_m_valid_clr", 32'(ifc3.m_valid_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
